vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 154 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable raster timing generator.
// All eight mode inputs are captured into a shadow copy at reset and at every
// frame wrap. Counting and decoding use only the shadow, so mid-frame mode edits
// take effect on the next frame. Every output is registered from the same
// next-pixel computation, so all outputs describe the pixel at (o_hpos, o_vpos).
// If the shadowed mode is invalid, the raster parks at (0,0) blanked. The shadow
// then reloads on every pixel strobe until a valid mode is captured.
module vga_timing_gen #(
    parameter int FW        = 13,
    parameter int LW        = 11,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_pixen,
    input  logic [FW-1:0] i_hm_width,
    input  logic [FW-1:0] i_hm_porch,
    input  logic [FW-1:0] i_hm_synch,
    input  logic [FW-1:0] i_hm_raw,
    input  logic [LW-1:0] i_vm_height,
    input  logic [LW-1:0] i_vm_porch,
    input  logic [LW-1:0] i_vm_synch,
    input  logic [LW-1:0] i_vm_raw,
    input  logic          i_int_ack,
    output logic [FW-1:0] o_hpos,
    output logic [LW-1:0] o_vpos,
    output logic          o_vga_hsync,
    output logic          o_vga_vsync,
    output logic          o_vga_blank,
    output logic          o_newline,
    output logic          o_newframe,
    output logic          o_interrupt,
    output logic          o_mode_err
);

    logic [FW-1:0] sh_width, sh_porch, sh_synch, sh_raw;
    logic [LW-1:0] sh_height, sh_vporch, sh_vsynch, sh_vraw;

    logic [FW-1:0] eff_width, eff_porch, eff_synch, eff_raw;
    logic [LW-1:0] eff_height, eff_vporch, eff_vsynch, eff_vraw;
    logic          eff_valid;

    logic          last_col;
    logic          frame_wrap;
    logic          load_shadow;

    logic [FW-1:0] nxt_hpos;
    logic [LW-1:0] nxt_vpos;
    logic          nxt_hsync, nxt_vsync, nxt_blank;
    logic          nxt_newline, nxt_newframe, nxt_interrupt;

    // Strictly increasing chain above 16 on both axes
    function automatic logic mode_ok(
        input logic [FW-1:0] w, input logic [FW-1:0] p,
        input logic [FW-1:0] s, input logic [FW-1:0] r,
        input logic [LW-1:0] h, input logic [LW-1:0] vp,
        input logic [LW-1:0] vs, input logic [LW-1:0] vr
    );
        return (w > FW'(16)) && (w < p) && (p < s) && (s < r) &&
               (h > LW'(16)) && (h < vp) && (vp < vs) && (vs < vr);
    endfunction

    // Wrap detection always uses the mode of the frame currently being drawn
    assign last_col    = (o_hpos == sh_raw - FW'(1));
    assign frame_wrap  = last_col && (o_vpos == sh_vraw - LW'(1));
    assign load_shadow = i_reset || (i_pixen && (o_mode_err || frame_wrap));

    // On a load cycle the decode of the next pixel must already see the new mode
    assign eff_width  = load_shadow ? i_hm_width  : sh_width;
    assign eff_porch  = load_shadow ? i_hm_porch  : sh_porch;
    assign eff_synch  = load_shadow ? i_hm_synch  : sh_synch;
    assign eff_raw    = load_shadow ? i_hm_raw    : sh_raw;
    assign eff_height = load_shadow ? i_vm_height : sh_height;
    assign eff_vporch = load_shadow ? i_vm_porch  : sh_vporch;
    assign eff_vsynch = load_shadow ? i_vm_synch  : sh_vsynch;
    assign eff_vraw   = load_shadow ? i_vm_raw    : sh_vraw;

    assign eff_valid = mode_ok(eff_width, eff_porch, eff_synch, eff_raw,
                               eff_height, eff_vporch, eff_vsynch, eff_vraw);

    // Next pixel position and its decoded outputs
    always_comb begin
        nxt_hpos      = o_hpos;
        nxt_vpos      = o_vpos;
        nxt_hsync     = o_vga_hsync;
        nxt_vsync     = o_vga_vsync;
        nxt_blank     = o_vga_blank;
        nxt_newline   = 1'b0;
        nxt_newframe  = 1'b0;
        nxt_interrupt = o_interrupt & ~i_int_ack;

        if (i_reset || i_pixen) begin
            if (i_reset || o_mode_err || !eff_valid) begin
                // Park at the origin; (0,0) is visible only when the mode is valid
                nxt_hpos  = '0;
                nxt_vpos  = '0;
                nxt_hsync = ~HSYNC_POL;
                nxt_vsync = ~VSYNC_POL;
                nxt_blank = ~eff_valid;
            end else begin
                if (last_col) begin
                    nxt_hpos = '0;
                    nxt_vpos = frame_wrap ? '0 : o_vpos + LW'(1);
                end else begin
                    nxt_hpos = o_hpos + FW'(1);
                    nxt_vpos = o_vpos;
                end
                nxt_blank    = ~((nxt_hpos < eff_width) && (nxt_vpos < eff_height));
                nxt_hsync    = ((nxt_hpos >= eff_porch) && (nxt_hpos < eff_synch))
                               ? HSYNC_POL : ~HSYNC_POL;
                nxt_vsync    = ((nxt_vpos >= eff_vporch) && (nxt_vpos < eff_vsynch))
                               ? VSYNC_POL : ~VSYNC_POL;
                nxt_newline  = (nxt_hpos == '0);
                nxt_newframe = (nxt_hpos == '0) && (nxt_vpos == '0);
                if ((nxt_hpos == '0) && (nxt_vpos == eff_height)) begin
                    nxt_interrupt = 1'b1;
                end
            end
        end

        if (i_reset) begin
            nxt_interrupt = 1'b0;
        end
    end

    // Shadow mode capture and validity flag
    always_ff @(posedge i_clk) begin
        if (load_shadow) begin
            sh_width   <= i_hm_width;
            sh_porch   <= i_hm_porch;
            sh_synch   <= i_hm_synch;
            sh_raw     <= i_hm_raw;
            sh_height  <= i_vm_height;
            sh_vporch  <= i_vm_porch;
            sh_vsynch  <= i_vm_synch;
            sh_vraw    <= i_vm_raw;
            o_mode_err <= ~eff_valid;
        end
    end

    // Output registers; every output comes from the same next-pixel decode
    always_ff @(posedge i_clk) begin
        o_hpos      <= nxt_hpos;
        o_vpos      <= nxt_vpos;
        o_vga_hsync <= nxt_hsync;
        o_vga_vsync <= nxt_vsync;
        o_vga_blank <= nxt_blank;
        o_newline   <= nxt_newline;
        o_newframe  <= nxt_newframe;
        o_interrupt <= nxt_interrupt;
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks vga_timing_gen against a linear pixel-index model
// plus directed scenarios with hand-computed expectations.
module tb_vga_timing_gen;

    localparam int FW = 13;
    localparam int LW = 11;
    localparam bit HP = 1'b0;
    localparam bit VP = 1'b0;

    logic          i_clk;
    logic          i_reset;
    logic          i_pixen;
    logic [FW-1:0] i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw;
    logic [LW-1:0] i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw;
    logic          i_int_ack;
    logic [FW-1:0] o_hpos;
    logic [LW-1:0] o_vpos;
    logic          o_vga_hsync, o_vga_vsync, o_vga_blank;
    logic          o_newline, o_newframe, o_interrupt, o_mode_err;

    int checks = 0;
    int errors = 0;

    vga_timing_gen #(.FW(FW), .LW(LW), .HSYNC_POL(HP), .VSYNC_POL(VP)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_pixen     (i_pixen),
        .i_hm_width  (i_hm_width),
        .i_hm_porch  (i_hm_porch),
        .i_hm_synch  (i_hm_synch),
        .i_hm_raw    (i_hm_raw),
        .i_vm_height (i_vm_height),
        .i_vm_porch  (i_vm_porch),
        .i_vm_synch  (i_vm_synch),
        .i_vm_raw    (i_vm_raw),
        .i_int_ack   (i_int_ack),
        .o_hpos      (o_hpos),
        .o_vpos      (o_vpos),
        .o_vga_hsync (o_vga_hsync),
        .o_vga_vsync (o_vga_vsync),
        .o_vga_blank (o_vga_blank),
        .o_newline   (o_newline),
        .o_newframe  (o_newframe),
        .o_interrupt (o_interrupt),
        .o_mode_err  (o_mode_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic set_mode(input int w, input int p, input int s, input int r,
                            input int h, input int vp, input int vs, input int vr);
        i_hm_width  = FW'(w);
        i_hm_porch  = FW'(p);
        i_hm_synch  = FW'(s);
        i_hm_raw    = FW'(r);
        i_vm_height = LW'(h);
        i_vm_porch  = LW'(vp);
        i_vm_synch  = LW'(vs);
        i_vm_raw    = LW'(vr);
    endtask

    // ---------------- model: frame position as a single pixel index ----------
    bit model_ok = 0;
    int m_w, m_p, m_s, m_r, m_h, m_vp, m_vs, m_vr;
    bit m_err;
    int m_pix;
    bit m_adv;
    bit m_int;

    task automatic model_load();
        m_w  = int'(i_hm_width);  m_p  = int'(i_hm_porch);
        m_s  = int'(i_hm_synch);  m_r  = int'(i_hm_raw);
        m_h  = int'(i_vm_height); m_vp = int'(i_vm_porch);
        m_vs = int'(i_vm_synch);  m_vr = int'(i_vm_raw);
        m_err = !(16 < m_w && m_w < m_p && m_p < m_s && m_s < m_r &&
                  16 < m_h && m_h < m_vp && m_vp < m_vs && m_vs < m_vr);
    endtask

    task automatic model_step();
        bit set_int;
        set_int = 0;
        m_adv = 0;
        if (i_reset) begin
            model_load();
            m_pix = 0;
            m_int = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (i_pixen) begin
                if (m_err) begin
                    model_load();
                    m_pix = 0;
                end else begin
                    m_pix++;
                    if (m_pix == m_r * m_vr) begin
                        m_pix = 0;
                        model_load();
                    end
                    if (!m_err) begin
                        m_adv = 1;
                        if (m_pix % m_r == 0 && m_pix / m_r == m_h) set_int = 1;
                    end
                end
            end
            if (set_int) m_int = 1;
            else if (i_int_ack) m_int = 0;
        end
    endtask

    initial forever begin
        @(posedge i_clk);
        model_step();
    end

    // ---------------- per-cycle compare ---------------------------------------
    task automatic compare();
        int eh, ev;
        bit eb, ehs, evs, enl, enf;
        if (m_err) begin
            eh = 0; ev = 0; eb = 1; ehs = !HP; evs = !VP; enl = 0; enf = 0;
        end else begin
            eh  = m_pix % m_r;
            ev  = m_pix / m_r;
            eb  = !(eh < m_w && ev < m_h);
            ehs = (eh >= m_p && eh < m_s) ? HP : !HP;
            evs = (ev >= m_vp && ev < m_vs) ? VP : !VP;
            enl = m_adv && eh == 0;
            enf = m_adv && m_pix == 0;
        end
        chk("m_hpos", 32'(o_hpos), eh);
        chk("m_vpos", 32'(o_vpos), ev);
        chk("m_blank", 32'(o_vga_blank), 32'(eb));
        chk("m_hsync", 32'(o_vga_hsync), 32'(ehs));
        chk("m_vsync", 32'(o_vga_vsync), 32'(evs));
        chk("m_newline", 32'(o_newline), 32'(enl));
        chk("m_newframe", 32'(o_newframe), 32'(enf));
        chk("m_interrupt", 32'(o_interrupt), 32'(m_int));
        chk("m_mode_err", 32'(o_mode_err), 32'(m_err));
    endtask

    initial forever begin
        @(negedge i_clk);
        if (model_ok) compare();
    end

    // ---------------- directed helpers ----------------------------------------
    task automatic adv_step(input bit toggle);
        if (toggle) i_pixen = ~i_pixen;
        step(1);
    endtask

    task automatic measure(input int n, input int exp, input string name, input bit toggle);
        bit found;
        int t;
        found = 0;
        for (int k = 0; k < 4 * exp && !found; k++) begin
            if (o_newframe) found = 1;
            else adv_step(toggle);
        end
        chk({name, "_sync"}, 32'(found), 1);
        if (!found) return;
        for (int f = 0; f < n; f++) begin
            adv_step(toggle);
            chk({name, "_pw"}, 32'(o_newframe), 0);
            t = 1;
            found = 0;
            while (!found && t < 4 * exp) begin
                if (o_newframe) found = 1;
                else begin
                    adv_step(toggle);
                    t++;
                end
            end
            chk({name, "_len"}, t, exp);
        end
    endtask

    // ---------------- stimulus -------------------------------------------------
    initial begin
        int hs_cnt, first_hs, blk, t;
        bit chg, hit;

        i_reset = 1; i_pixen = 0; i_int_ack = 0;
        set_mode(20, 22, 25, 28, 18, 19, 21, 23);
        step(3);
        chk("rst_hpos", 32'(o_hpos), 0);
        chk("rst_vpos", 32'(o_vpos), 0);
        chk("rst_blank", 32'(o_vga_blank), 0);
        chk("rst_hsync", 32'(o_vga_hsync), 1);
        chk("rst_vsync", 32'(o_vga_vsync), 1);
        chk("rst_err", 32'(o_mode_err), 0);
        chk("rst_int", 32'(o_interrupt), 0);
        chk("rst_newframe", 32'(o_newframe), 0);

        i_reset = 0; i_pixen = 1;
        step(1);
        chk("first_pix_hpos", 32'(o_hpos), 1);
        chk("first_pix_nf", 32'(o_newframe), 0);

        // one whole line: hsync window and blank columns
        hit = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (o_newline) hit = 1; else step(1);
        end
        chk("line_sync", 32'(hit), 1);
        hs_cnt = 0; first_hs = -1; blk = 0;
        for (int c = 0; c < 28; c++) begin
            if (o_vga_hsync == 1'b0) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = int'(o_hpos);
            end
            blk += int'(o_vga_blank);
            step(1);
        end
        chk("hsync_width", hs_cnt, 3);
        chk("hsync_start", first_hs, 22);
        chk("blank_cols", blk, 8);

        // interrupt rises with (0,18)
        hit = 0;
        for (int k = 0; k < 1000 && !hit; k++) begin
            if (o_interrupt) hit = 1; else step(1);
        end
        chk("int_rise_seen", 32'(hit), 1);
        chk("int_rise_hpos", 32'(o_hpos), 0);
        chk("int_rise_vpos", 32'(o_vpos), 18);

        // ack on an idle cycle
        i_pixen = 0; i_int_ack = 1;
        step(1);
        chk("int_ack_idle", 32'(o_interrupt), 0);
        chk("idle_hold_vpos", 32'(o_vpos), 18);
        i_int_ack = 0; i_pixen = 1;

        // vsync at line 19 of the same frame
        hit = 0;
        for (int k = 0; k < 1000 && !hit; k++) begin
            if (o_vpos == 19) hit = 1; else step(1);
        end
        chk("vsync_line_seen", 32'(hit), 1);
        chk("vsync_19", 32'(o_vga_vsync), 0);
        chk("vblank_19", 32'(o_vga_blank), 1);

        // ack coincident with next (0,18): set wins
        hit = 0;
        for (int k = 0; k < 1000 && !hit; k++) begin
            if (o_hpos == 27 && o_vpos == 17) hit = 1; else step(1);
        end
        chk("pre_int_seen", 32'(hit), 1);
        i_int_ack = 1;
        step(1);
        i_int_ack = 0;
        chk("int_set_wins", 32'(o_interrupt), 1);
        chk("int_set_vpos", 32'(o_vpos), 18);

        measure(2, 644, "frame_pix1", 0);
        measure(2, 1288, "frame_toggle", 1);
        i_pixen = 1;

        // mode edit mid-frame applies only from the next frame
        hit = 0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            if (o_newframe) hit = 1; else step(1);
        end
        chk("chg_sync", 32'(hit), 1);
        chg = 0; t = 0;
        step(1); t = 1;
        while (!o_newframe && t < 3000) begin
            if (!chg && o_vpos == 5) begin
                set_mode(30, 32, 35, 38, 18, 19, 21, 23);
                chg = 1;
            end
            step(1);
            t++;
        end
        chk("old_frame_len", t, 644);
        t = 0;
        step(1); t = 1;
        while (!o_newline && t < 200) begin
            step(1);
            t++;
        end
        chk("new_line_len", t, 38);

        // reset pulsed at (10,7)
        hit = 0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            if (o_hpos == 10 && o_vpos == 7) hit = 1; else step(1);
        end
        chk("rst_point_seen", 32'(hit), 1);
        chk("pre_rst_int", 32'(o_interrupt), 1);
        i_reset = 1;
        step(1);
        i_reset = 0;
        chk("midrst_hpos", 32'(o_hpos), 0);
        chk("midrst_vpos", 32'(o_vpos), 0);
        chk("midrst_int", 32'(o_interrupt), 0);
        step(1);
        chk("midrst_resume", 32'(o_hpos), 1);
        measure(1, 874, "frame_38", 0);

        // invalid mode at reset, then recovery
        set_mode(16, 22, 25, 28, 18, 19, 21, 23);
        i_reset = 1;
        step(2);
        i_reset = 0;
        chk("err_set", 32'(o_mode_err), 1);
        chk("err_blank_rst", 32'(o_vga_blank), 1);
        step(5);
        chk("err_hpos", 32'(o_hpos), 0);
        chk("err_vpos", 32'(o_vpos), 0);
        chk("err_blank", 32'(o_vga_blank), 1);
        chk("err_hsync", 32'(o_vga_hsync), 1);
        set_mode(20, 22, 25, 28, 18, 19, 21, 23);
        step(1);
        chk("err_clear", 32'(o_mode_err), 0);
        chk("err_clear_blank", 32'(o_vga_blank), 0);
        step(3);
        chk("err_count_start", 32'(o_hpos), 3);
        measure(1, 644, "frame_after_err", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
